// File: rtl/groove_pkg.sv
// Shared constants, FSM state and scan-length clamp for the groove-scan synthesizer.
// Imported by groove_offset_mul and groove_scan_synth.
package groove_pkg;

  localparam int SAMPLE_W = 16;
  localparam int TIME_W   = 32;
  localparam int MIN_SCAN = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  function automatic logic [TIME_W-1:0] clamp_scan(
    input logic [TIME_W-1:0] afll,
    input logic [TIME_W-1:0] min_len
  );
    return (afll < min_len) ? min_len : afll;
  endfunction

endpackage

// File: rtl/groove_scan_synth_if.sv
// Sample stream handshake feeding the scan synthesizer.
// master: sample_in/sample_valid out, sample_ready in; slave: the reverse.
interface groove_scan_synth_if;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        sample_ready;

  modport master (
    output sample_in,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_in,
    input  sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/groove_offset_mul.sv
// Registered 16x32 unsigned multiply returning product bits [47:16].
// Ports: clk, reset_n (sync, low), clear, start, a, b -> product, valid.
module groove_offset_mul
  import groove_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              start,
  input  logic [SAMPLE_W-1:0] a,
  input  logic [TIME_W-1:0] b,
  output logic [TIME_W-1:0] product,
  output logic              valid
);

  localparam int FULL_W = SAMPLE_W + TIME_W;

  logic [FULL_W-1:0] a_ext;
  logic [FULL_W-1:0] b_ext;
  logic [TIME_W-1:0] hi;

  assign a_ext = {{TIME_W{1'b0}}, a};
  assign b_ext = {{SAMPLE_W{1'b0}}, b};
  assign hi    = TIME_W'((a_ext * b_ext) >> SAMPLE_W);

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      product <= '0;
      valid   <= 1'b0;
    end else if (start) begin
      product <= hi;
      valid   <= 1'b1;
    end
  end

endmodule

// File: rtl/groove_scan_synth.sv
// Groove-scan stimulus generator: alternating LTR/RTL scans, one sig per scan.
// Ports: clk, reset_n (sync, low), enable, afll_ltr/rtl, smp (sample handshake),
// sync_start, dir, sig, timestamp, sig_time, underrun, underrun_count.
// Macro GSS_UNDERRUN_CNT_EN enables the saturating silent-scan counter.
module groove_scan_synth #(
  parameter int unsigned MIN_SCAN = groove_pkg::MIN_SCAN
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [31:0] afll_ltr,
  input  logic [31:0] afll_rtl,
  groove_scan_synth_if.slave smp,
  output logic        sync_start,
  output logic        dir,
  output logic        sig,
  output logic [31:0] timestamp,
  output logic [31:0] sig_time,
  output logic        underrun,
  output logic [15:0] underrun_count
);

  import groove_pkg::*;

  localparam logic [TIME_W-1:0] MIN_LEN = TIME_W'(MIN_SCAN);

  state_t              state;
  logic [TIME_W-1:0]   cnt;
  logic [TIME_W-1:0]   d_len;
  logic [TIME_W-1:0]   cur_off;
  logic [TIME_W-1:0]   ts;
  logic [TIME_W-1:0]   sig_ts;
  logic                dir_q;
  logic                pending;
  logic                go;
  logic                armed;
  logic                unr;
  logic [SAMPLE_W-1:0] smp_q;

  logic                in_scan;
  logic                last;
  logic                ready;
  logic                hs;
  logic                silent;
  logic                mul_clr;
  logic [TIME_W-1:0]   afll_nxt;
  logic [TIME_W-1:0]   d_nxt;
  logic [TIME_W-1:0]   off_clamp;
  logic [TIME_W-1:0]   prod;
  logic                prod_v;

  assign in_scan  = (state == SCAN);
  assign last     = in_scan && (cnt == d_len - 1);
  assign ready    = in_scan && !pending && (cnt <= d_len - 3);
  assign hs       = ready && smp.sample_valid;
  // afll of the scan the pending sample will land in.
  assign afll_nxt = dir_q ? afll_ltr : afll_rtl;
  assign d_nxt    = clamp_scan(afll_nxt, MIN_LEN);
  assign off_clamp = (prod > d_nxt - 1) ? d_nxt - 1 : prod;
  assign silent   = last && enable && !prod_v;
  assign mul_clr  = !in_scan || !enable || last;

  groove_offset_mul u_mul (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (mul_clr),
    .start   (go),
    .a       (smp_q ^ 16'h8000),
    .b       (afll_nxt),
    .product (prod),
    .valid   (prod_v)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      d_len   <= MIN_LEN;
      cur_off <= '0;
      ts      <= '0;
      sig_ts  <= '0;
      dir_q   <= 1'b0;
      pending <= 1'b0;
      go      <= 1'b0;
      armed   <= 1'b0;
      unr     <= 1'b0;
      smp_q   <= '0;
    end else begin
      ts <= ts + 1'b1;
      go <= hs && enable;
      if (sig) sig_ts <= ts;
      unique case (state)
        IDLE: begin
          if (enable) begin
            state <= SCAN;
            cnt   <= '0;
            dir_q <= 1'b0;
            d_len <= clamp_scan(afll_ltr, MIN_LEN);
          end
        end
        SCAN: begin
          if (!enable) begin
            state   <= IDLE;
            cnt     <= '0;
            dir_q   <= 1'b0;
            pending <= 1'b0;
            armed   <= 1'b0;
          end else if (last) begin
            cnt     <= '0;
            dir_q   <= ~dir_q;
            d_len   <= d_nxt;
            pending <= 1'b0;
            armed   <= prod_v;
            if (prod_v) cur_off <= off_clamp;
            else        unr     <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
            if (hs) begin
              pending <= 1'b1;
              smp_q   <= smp.sample_in;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GSS_UNDERRUN_CNT_EN
  logic [15:0] unr_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      unr_cnt <= '0;
    end else if (silent && unr_cnt != 16'hFFFF) begin
      unr_cnt <= unr_cnt + 1'b1;
    end
  end

  assign underrun_count = unr_cnt;
`else
  assign underrun_count = '0;
`endif

  assign smp.sample_ready = ready;
  assign sync_start = in_scan && (cnt == '0);
  assign sig        = in_scan && armed && (cnt == cur_off);
  assign dir        = dir_q;
  assign timestamp  = ts;
  assign sig_time   = sig_ts;
  assign underrun   = unr;

endmodule

// File: tb/tb_groove_scan_synth.sv
// Directed self-checking bench for groove_scan_synth.
// Scenarios: reset, offset mapping, asymmetric afll, underrun, min scan, reset mid-scan.
module tb_groove_scan_synth;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [31:0] afll_ltr;
  logic [31:0] afll_rtl;
  logic        sync_start;
  logic        dir;
  logic        sig;
  logic [31:0] timestamp;
  logic [31:0] sig_time;
  logic        underrun;
  logic [15:0] underrun_count;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  groove_scan_synth_if sif ();

  groove_scan_synth dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .afll_ltr       (afll_ltr),
    .afll_rtl       (afll_rtl),
    .smp            (sif),
    .sync_start     (sync_start),
    .dir            (dir),
    .sig            (sig),
    .timestamp      (timestamp),
    .sig_time       (sig_time),
    .underrun       (underrun),
    .underrun_count (underrun_count)
  );

  task automatic wait_sync(input int budget);
    bit found = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (sync_start) begin
        found = 1;
        break;
      end
    end
    total++;
    if (!found) $display("FAIL wait_sync got timeout want sync_start");
    else passed++;
  endtask

  // Entered at the negedge of a scan's cycle 0; returns at the next one.
  task automatic watch_scan(
    input  bit          offer,
    input  bit          stream,
    input  logic [15:0] s,
    output int          len,
    output int          sig_c,
    output int          n_sig,
    output int          acc,
    output logic [31:0] ts0,
    output logic        d0,
    output logic [7:0]  rdy
  );
    bit hs;
    bit done = 0;
    len = -1; sig_c = -1; n_sig = 0; acc = 0; rdy = '0;
    ts0 = timestamp;
    d0  = dir;
    if (offer) begin
      sif.sample_in    = s;
      sif.sample_valid = 1'b1;
    end
    for (int k = 0; k < 5000; k++) begin
      if (k > 0 && sync_start) begin
        len  = k;
        done = 1;
        break;
      end
      if (k < 8) rdy[k] = sif.sample_ready;
      if (sig) begin
        n_sig++;
        if (sig_c < 0) sig_c = k;
      end
      hs = sif.sample_valid && sif.sample_ready;
      if (hs) acc++;
      @(negedge clk);
      if (hs && !stream) sif.sample_valid = 1'b0;
    end
    total++;
    if (!done) $display("FAIL watch_scan got timeout want scan end");
    else passed++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    enable  = 1'b0;
    afll_ltr = 32'd1000;
    afll_rtl = 32'd1000;
    sif.sample_in    = '0;
    sif.sample_valid = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({sync_start, dir, sig, underrun, sif.sample_ready} !== 5'b0)
      $display("FAIL reset_flags got %b want 00000",
               {sync_start, dir, sig, underrun, sif.sample_ready});
    else passed++;
    total++;
    if (timestamp !== 32'd0 || sig_time !== 32'd0)
      $display("FAIL reset_time got %0d/%0d want 0/0", timestamp, sig_time);
    else passed++;
    total++;
    if (underrun_count !== 16'd0)
      $display("FAIL reset_ucnt got %0d want 0", underrun_count);
    else passed++;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (timestamp !== 32'd3)
      $display("FAIL idle_ts got %0d want 3", timestamp);
    else passed++;
    total++;
    if (sync_start !== 1'b0)
      $display("FAIL idle_sync got %b want 0", sync_start);
    else passed++;
  endtask

  task automatic test_offsets();
    int len, sc, ns, acc;
    logic [31:0] t0;
    logic d;
    logic [7:0] rb;
    logic [15:0] exp_cnt;
`ifdef GSS_UNDERRUN_CNT_EN
    exp_cnt = 16'd2;
`else
    exp_cnt = 16'd0;
`endif
    enable = 1'b1;
    wait_sync(10);
    watch_scan(1, 0, 16'h0000, len, sc, ns, acc, t0, d, rb);
    total++;
    if (ns !== 0 || d !== 1'b0 || len !== 1000)
      $display("FAIL first_scan got sig=%0d dir=%b len=%0d want 0/0/1000", ns, d, len);
    else passed++;
    watch_scan(1, 0, 16'h8000, len, sc, ns, acc, t0, d, rb);
    total++;
    if (ns !== 1 || sc !== 500 || d !== 1'b1)
      $display("FAIL mid_sig got n=%0d c=%0d dir=%b want 1/500/1", ns, sc, d);
    else passed++;
    total++;
    if (sig_time - t0 !== 32'd500)
      $display("FAIL mid_sig_time got %0d want 500", sig_time - t0);
    else passed++;
    watch_scan(1, 0, 16'h7FFF, len, sc, ns, acc, t0, d, rb);
    total++;
    if (ns !== 1 || sc !== 0 || d !== 1'b0)
      $display("FAIL min_sig got n=%0d c=%0d dir=%b want 1/0/0", ns, sc, d);
    else passed++;
    total++;
    if (sig_time !== t0)
      $display("FAIL min_sig_time got %0d want %0d", sig_time, t0);
    else passed++;
    total++;
    if (underrun !== 1'b0)
      $display("FAIL no_underrun got %b want 0", underrun);
    else passed++;
    watch_scan(0, 0, 16'h0000, len, sc, ns, acc, t0, d, rb);
    total++;
    if (ns !== 1 || sc !== 999 || d !== 1'b1)
      $display("FAIL max_sig got n=%0d c=%0d dir=%b want 1/999/1", ns, sc, d);
    else passed++;
    total++;
    if (sig_time - t0 !== 32'd999)
      $display("FAIL max_sig_time got %0d want 999", sig_time - t0);
    else passed++;
    watch_scan(0, 0, 16'h0000, len, sc, ns, acc, t0, d, rb);
    total++;
    if (ns !== 0 || len !== 1000)
      $display("FAIL silent1 got n=%0d len=%0d want 0/1000", ns, len);
    else passed++;
    watch_scan(1, 0, 16'h0000, len, sc, ns, acc, t0, d, rb);
    total++;
    if (ns !== 0 || d !== 1'b1)
      $display("FAIL silent2 got n=%0d dir=%b want 0/1", ns, d);
    else passed++;
    total++;
    if (underrun !== 1'b1)
      $display("FAIL underrun got %b want 1", underrun);
    else passed++;
    total++;
    if (underrun_count !== exp_cnt)
      $display("FAIL underrun_count got %0d want %0d", underrun_count, exp_cnt);
    else passed++;
    watch_scan(0, 0, 16'h0000, len, sc, ns, acc, t0, d, rb);
    total++;
    if (ns !== 1 || sc !== 500 || d !== 1'b0)
      $display("FAIL resume_sig got n=%0d c=%0d dir=%b want 1/500/0", ns, sc, d);
    else passed++;
    enable = 1'b0;
    @(negedge clk);
    total++;
    if ({sync_start, dir, sif.sample_ready} !== 3'b0)
      $display("FAIL disable got %b want 000", {sync_start, dir, sif.sample_ready});
    else passed++;
  endtask

  task automatic test_asym();
    int len, sc, ns, acc;
    logic [31:0] t0;
    logic d;
    logic [7:0] rb;
    afll_ltr = 32'd1000;
    afll_rtl = 32'd600;
    enable = 1'b1;
    wait_sync(10);
    watch_scan(1, 0, 16'h4000, len, sc, ns, acc, t0, d, rb);
    total++;
    if (d !== 1'b0 || len !== 1000)
      $display("FAIL asym_s0 got dir=%b len=%0d want 0/1000", d, len);
    else passed++;
    watch_scan(0, 0, 16'h0000, len, sc, ns, acc, t0, d, rb);
    total++;
    if (d !== 1'b1 || len !== 600 || ns !== 1 || sc !== 450)
      $display("FAIL asym_s1 got dir=%b len=%0d n=%0d c=%0d want 1/600/1/450",
               d, len, ns, sc);
    else passed++;
    watch_scan(0, 0, 16'h0000, len, sc, ns, acc, t0, d, rb);
    total++;
    if (d !== 1'b0)
      $display("FAIL asym_s2 got dir=%b want 0", d);
    else passed++;
    enable = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_min_scan();
    int len, sc, ns, acc;
    logic [31:0] t0;
    logic d;
    logic [7:0] rb;
    afll_ltr = 32'd0;
    afll_rtl = 32'd0;
    enable = 1'b1;
    wait_sync(10);
    watch_scan(0, 0, 16'h0000, len, sc, ns, acc, t0, d, rb);
    total++;
    if (len !== 4 || rb[3:0] !== 4'b0011)
      $display("FAIL min_ready got len=%0d rdy=%b want 4/0011", len, rb[3:0]);
    else passed++;
    watch_scan(1, 1, 16'h1234, len, sc, ns, acc, t0, d, rb);
    total++;
    if (acc !== 1 || ns !== 0)
      $display("FAIL b2b_s1 got acc=%0d n=%0d want 1/0", acc, ns);
    else passed++;
    watch_scan(1, 1, 16'h5678, len, sc, ns, acc, t0, d, rb);
    total++;
    if (acc !== 1 || ns !== 1 || sc !== 0 || len !== 4)
      $display("FAIL b2b_s2 got acc=%0d n=%0d c=%0d len=%0d want 1/1/0/4",
               acc, ns, sc, len);
    else passed++;
    watch_scan(1, 1, 16'h9ABC, len, sc, ns, acc, t0, d, rb);
    total++;
    if (ns !== 1 || acc !== 1)
      $display("FAIL b2b_s3 got n=%0d acc=%0d want 1/1", ns, acc);
    else passed++;
    sif.sample_valid = 1'b0;
    enable = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int len, sc, ns, acc;
    logic [31:0] t0;
    logic d;
    logic [7:0] rb;
    afll_ltr = 32'd1000;
    afll_rtl = 32'd1000;
    enable = 1'b1;
    wait_sync(10);
    sif.sample_in    = 16'h0000;
    sif.sample_valid = 1'b1;
    @(negedge clk);
    sif.sample_valid = 1'b0;
    repeat (5) @(negedge clk);
    total++;
    if (sif.sample_ready !== 1'b0)
      $display("FAIL pending_ready got %b want 0", sif.sample_ready);
    else passed++;
    reset_n = 1'b0;
    enable  = 1'b0;
    @(negedge clk);
    total++;
    if ({sync_start, dir, sig, underrun, sif.sample_ready} !== 5'b0)
      $display("FAIL midrst_flags got %b want 00000",
               {sync_start, dir, sig, underrun, sif.sample_ready});
    else passed++;
    total++;
    if (timestamp !== 32'd0 || sig_time !== 32'd0 || underrun_count !== 16'd0)
      $display("FAIL midrst_regs got %0d/%0d/%0d want 0/0/0",
               timestamp, sig_time, underrun_count);
    else passed++;
    reset_n = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    wait_sync(10);
    watch_scan(0, 0, 16'h0000, len, sc, ns, acc, t0, d, rb);
    total++;
    if (ns !== 0 || d !== 1'b0)
      $display("FAIL post_rst_scan got n=%0d dir=%b want 0/0", ns, d);
    else passed++;
    enable = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_offsets();
    test_asym();
    test_min_scan();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/groove_scan_synth.md
# groove_scan_synth

Generates the groove-scan stimulus that `groove_sample_timestamp`-style receivers decode. It consumes signed 16-bit audio samples and emits the matching events:
- alternating LTR/RTL scans, each opened by a `sync_start` pulse;
- one `sig` strobe per scan, placed at a time offset proportional to the sample;
- a free-running timestamp.

It sits on the loopback/test path as the transmit end of the scan-timing interface.

## Interface
- `MIN_SCAN`, default 4: minimum scan length in clk cycles; smaller `afll_*` values are clamped up to it.
- `clk`  in  1  clock.
- `reset_n`  in  1  reset, synchronous, active-low.
- `enable`  in  1  run; low forces IDLE.
- `afll_ltr`  in  32  LTR scan length in cycles; quasi-static.
- `afll_rtl`  in  32  RTL scan length in cycles; quasi-static.
- `sample_in`  in  16  signed audio sample.
- `sample_valid`  in  1  upstream offers `sample_in`.
- `sample_ready`  out  1  block accepts this cycle.
- `sync_start`  out  1  one-cycle pulse at scan cycle 0.
- `dir`  out  1  0 = LTR, 1 = RTL; constant for the whole scan.
- `sig`  out  1  one-cycle strobe at the sample offset.
- `timestamp`  out  32  free-running cycle counter; wraps.
- `sig_time`  out  32  value of `timestamp` during the last `sig` cycle.
- `underrun`  out  1  sticky; set on any silent scan.
- `underrun_count`  out  16  saturating silent-scan count.

## Operation
- States: IDLE, SCAN.
  - IDLE → SCAN on the first cycle with `enable` high. Entry cycle = scan cycle 0 with `dir` = 0.
  - SCAN → IDLE the cycle after `enable` goes low. This aborts the scan, clears pending/product/armed, and resets `dir` to 0.
- Scan length D = max(afll for current `dir`, MIN_SCAN), latched at cycle 0. Scan counter c runs 0..D-1.
- At c == D-1, the next cycle starts a new scan at c = 0 with `dir` toggled.
- `sync_start` = 1 exactly when c == 0. Because D ≥ 4, consecutive pulses are separated by low cycles.
- Sample path:
  - `sample_ready` = SCAN && !pending && c ≤ D-3.
  - On handshake: pending ← 1, sample held.
  - Next cycle, `groove_offset_mul` computes offset = ((sample ^ 16'h8000) × afll(~dir)) >> 16 and sets product_valid.
- At c == D-1 with product_valid:
  - armed ← 1, cur_offset ← min(offset, D'-1), where D' is the next scan's clamped length;
  - pending and product_valid are cleared.
- At c == D-1 without product_valid: the next scan is silent (armed ← 0). It still emits `sync_start`, has no `sig`, and sets `underrun`.
- `sig` = 1 when armed && c == cur_offset. Offset 0 coincides with `sync_start`, which is legal.
- The `afll_*` inputs must be stable while `enable` is high. A change mid-run is absorbed by the offset clamp and is otherwise not guaranteed.

## Timing
- Reset values: all outputs 0; internal state IDLE, `dir` 0, `timestamp` 0.
- `timestamp` increments every cycle, including in IDLE, and wraps 2^32 → 0. Receivers subtract modulo 2^32.
- `sig_time` updates on the clock edge closing the `sig` cycle, so it is visible one cycle after `sig`.
- Sample latency: a sample accepted at cycle c ≤ D-3 of scan N appears as `sig` in scan N+1. Acceptance is blocked at c ≥ D-2, so no sample can straddle a direction change.
- Multiplier latency: 1 cycle, registered.
- Simultaneous `enable` fall and `sig`: `enable` wins; `sig` is still emitted that cycle, and IDLE follows next cycle.
- Reset mid-scan: immediate return to reset values; the pending sample is discarded.

## Configuration
- `GSS_UNDERRUN_CNT_EN` defined: `underrun_count` increments (saturating at 16'hFFFF) on each silent scan, and clears only on reset.
- Not defined: `underrun_count` is tied to 0 and the counter logic is removed. The sticky `underrun` flag is present in both builds.

## Structure
- Package `groove_pkg`:
  - `SAMPLE_W` = 16, `TIME_W` = 32, `MIN_SCAN` default;
  - state enum {IDLE, SCAN};
  - function `clamp_scan(afll)`.
- Sub-module `groove_offset_mul`: registered 16×32 unsigned multiply giving bits [47:16] and a valid flag.

## Test plan
- LTR = 1000, sample 0 accepted during scan 0 → scan 1 (RTL = 1000): `sig` at c = 500; `sig_time` − `timestamp`@`sync_start` = 500.
- Samples −32768 and 32767, D = 1000 → `sig` at c = 0 (same cycle as `sync_start`) and c = 999 respectively.
- LTR = 1000, RTL = 600, sample 16384 targeting RTL → `sig` at c = 450; `dir` alternates 0, 1, 0 with each `sync_start`.
- `sample_valid` held low for 2 scans → 2 silent scans: `sync_start` present, no `sig`, `underrun` = 1, `underrun_count` = 2 with the macro and 0 without.
- `afll_ltr` = 0 → scans last 4 cycles; `sample_ready` is high only at c ≤ 1; back-to-back samples produce one `sig` per scan.
- `reset_n` low mid-scan with pending full → next cycle all outputs 0; after release and `enable`, the first scan is silent.
